// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one CPU-style memory port (address/data/size/enable/operation/ready)
// between two requesters, port0 and port1, using an enable/ready full handshake on both sides.
// Exactly one memory transaction is outstanding at any time.
//
// Parameters:
//   ROUND_ROBIN    - 1: simultaneous requests alternate; 0: port0 always wins.
//   TIMEOUT_CYCLES - cycles spent in ISSUE before the watchdog forces completion; 0 disables it.
//   TIMEOUT_WIDTH  - width of the watchdog counter; must hold TIMEOUT_CYCLES.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset.
//   portN_address/data_out/data_size/enable/operation
//                           - requester N request (held until portN_ready).
//   portN_data_in/ready     - requester N read data and completion.
//   memory_address/data_out/data_size/enable/operation
//                           - registered request to the memory.
//   memory_data_in/ready    - memory read data and completion.
//   grant                   - port owning the current or last transaction.
//   timeout_error           - watchdog fired; cleared when the next transaction starts.
module memory_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] port0_address,
    input  logic [31:0] port0_data_out,
    input  logic [1:0]  port0_data_size,
    input  logic        port0_enable,
    input  logic        port0_operation,
    output logic [31:0] port0_data_in,
    output logic        port0_ready,

    input  logic [31:0] port1_address,
    input  logic [31:0] port1_data_out,
    input  logic [1:0]  port1_data_size,
    input  logic        port1_enable,
    input  logic        port1_operation,
    output logic [31:0] port1_data_in,
    output logic        port1_ready,

    output logic [31:0] memory_address,
    output logic [31:0] memory_data_out,
    output logic [1:0]  memory_data_size,
    output logic        memory_enable,
    output logic        memory_operation,
    input  logic [31:0] memory_data_in,
    input  logic        memory_ready,

    output logic        grant,
    output logic        timeout_error
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRespond,
        StRelease
    } state_e;

    localparam bit WatchdogEn = (TIMEOUT_CYCLES != 0);
    // Last counter value before the forced completion; only meaningful when WatchdogEn.
    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                   state_q;
    logic                     last_grant_q;
    logic                     grant_q;
    logic                     timeout_q;
    logic [TIMEOUT_WIDTH-1:0] wdog_q;

    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_size_q;
    logic        mem_en_q;
    logic        mem_op_q;

    logic [31:0] p0_din_q;
    logic [31:0] p1_din_q;
    logic        p0_rdy_q;
    logic        p1_rdy_q;

    logic req_any;
    logic win;
    logic gnt_enable;
    logic timeout_hit;

    always_comb begin
        req_any = port0_enable | port1_enable;
        win     = 1'b0;
        if (port0_enable && port1_enable) begin
            win = ROUND_ROBIN ? ~last_grant_q : 1'b0;
        end else if (port1_enable) begin
            win = 1'b1;
        end
        gnt_enable  = grant_q ? port1_enable : port0_enable;
        timeout_hit = WatchdogEn && (wdog_q == TimeoutLast);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            timeout_q    <= 1'b0;
            wdog_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_op_q     <= 1'b0;
            p0_din_q     <= '0;
            p1_din_q     <= '0;
            p0_rdy_q     <= 1'b0;
            p1_rdy_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        mem_addr_q   <= win ? port1_address   : port0_address;
                        mem_wdata_q  <= win ? port1_data_out  : port0_data_out;
                        mem_size_q   <= win ? port1_data_size : port0_data_size;
                        mem_op_q     <= win ? port1_operation : port0_operation;
                        grant_q      <= win;
                        last_grant_q <= win;
                        timeout_q    <= 1'b0;
                        wdog_q       <= '0;
                        mem_en_q     <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    if (memory_ready) begin
                        if (!mem_op_q) begin
                            if (grant_q) p1_din_q <= memory_data_in;
                            else         p0_din_q <= memory_data_in;
                        end
                        mem_en_q <= 1'b0;
                        if (grant_q) p1_rdy_q <= 1'b1;
                        else         p0_rdy_q <= 1'b1;
                        state_q  <= StRespond;
                    end else begin
                        wdog_q <= wdog_q + TIMEOUT_WIDTH'(1);
                        if (timeout_hit) begin
                            // Stalled memory: complete with zero read data and flag it.
                            if (!mem_op_q) begin
                                if (grant_q) p1_din_q <= '0;
                                else         p0_din_q <= '0;
                            end
                            timeout_q <= 1'b1;
                            mem_en_q  <= 1'b0;
                            if (grant_q) p1_rdy_q <= 1'b1;
                            else         p0_rdy_q <= 1'b1;
                            state_q   <= StRespond;
                        end
                    end
                end
                StRespond: begin
                    if (!gnt_enable) begin
                        p0_rdy_q <= 1'b0;
                        p1_rdy_q <= 1'b0;
                        state_q  <= StRelease;
                    end
                end
                StRelease: begin
                    // Memory must drop ready before another access can start.
                    if (!memory_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign memory_address   = mem_addr_q;
    assign memory_data_out  = mem_wdata_q;
    assign memory_data_size = mem_size_q;
    assign memory_enable    = mem_en_q;
    assign memory_operation = mem_op_q;
    assign port0_data_in    = p0_din_q;
    assign port1_data_in    = p1_din_q;
    assign port0_ready      = p0_rdy_q;
    assign port1_ready      = p1_rdy_q;
    assign grant            = grant_q;
    assign timeout_error    = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter. Instance 0: round-robin with an 8-cycle watchdog.
// Instance 1: fixed priority. Each memory side is a small latency model.
module tb_memory_arbiter;

    logic clock;
    logic reset;

    // Requester side, indexed [instance][port].
    logic [31:0] r_addr  [2][2];
    logic [31:0] r_wdata [2][2];
    logic [1:0]  r_size  [2][2];
    logic        r_en    [2][2];
    logic        r_op    [2][2];
    logic [31:0] r_din   [2][2];
    logic        r_rdy   [2][2];

    // Memory side, indexed [instance].
    logic [31:0] m_addr  [2];
    logic [31:0] m_dout  [2];
    logic [1:0]  m_size  [2];
    logic        m_en    [2];
    logic        m_op    [2];
    logic [31:0] m_din   [2];
    logic        m_rdy   [2];
    logic        gnt     [2];
    logic        terr    [2];

    int m_lat [2];
    int m_cnt [2];
    logic m_en_prev [2];

    int n_cmp;
    int n_err;

    typedef struct {
        int          d;
        int          p;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        op;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          p;
        logic        op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          hold;
        logic [31:0] exp_din;
    } vec_t;
    vec_t vecs[5];

    logic [31:0] model_din [2][2];

    memory_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)) u_dut_rr (
        .clock(clock), .reset(reset),
        .port0_address(r_addr[0][0]), .port0_data_out(r_wdata[0][0]),
        .port0_data_size(r_size[0][0]), .port0_enable(r_en[0][0]),
        .port0_operation(r_op[0][0]), .port0_data_in(r_din[0][0]), .port0_ready(r_rdy[0][0]),
        .port1_address(r_addr[0][1]), .port1_data_out(r_wdata[0][1]),
        .port1_data_size(r_size[0][1]), .port1_enable(r_en[0][1]),
        .port1_operation(r_op[0][1]), .port1_data_in(r_din[0][1]), .port1_ready(r_rdy[0][1]),
        .memory_address(m_addr[0]), .memory_data_out(m_dout[0]),
        .memory_data_size(m_size[0]), .memory_enable(m_en[0]),
        .memory_operation(m_op[0]), .memory_data_in(m_din[0]), .memory_ready(m_rdy[0]),
        .grant(gnt[0]), .timeout_error(terr[0])
    );

    memory_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(255), .TIMEOUT_WIDTH(16)) u_dut_fp (
        .clock(clock), .reset(reset),
        .port0_address(r_addr[1][0]), .port0_data_out(r_wdata[1][0]),
        .port0_data_size(r_size[1][0]), .port0_enable(r_en[1][0]),
        .port0_operation(r_op[1][0]), .port0_data_in(r_din[1][0]), .port0_ready(r_rdy[1][0]),
        .port1_address(r_addr[1][1]), .port1_data_out(r_wdata[1][1]),
        .port1_data_size(r_size[1][1]), .port1_enable(r_en[1][1]),
        .port1_operation(r_op[1][1]), .port1_data_in(r_din[1][1]), .port1_ready(r_rdy[1][1]),
        .memory_address(m_addr[1]), .memory_data_out(m_dout[1]),
        .memory_data_size(m_size[1]), .memory_enable(m_en[1]),
        .memory_operation(m_op[1]), .memory_data_in(m_din[1]), .memory_ready(m_rdy[1]),
        .grant(gnt[1]), .timeout_error(terr[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running, want finished");
        $fatal(1, "simulation time limit reached");
    end

    // Memory contents: 0x100 holds 0x12345678, everything else is address-derived.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    function automatic void sb_push(input int d, input int p, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [1:0] size,
                                    input logic op);
        sb_t e;
        e.d = d; e.p = p; e.addr = addr; e.wdata = wdata; e.size = size; e.op = op;
        sb_q.push_back(e);
    endfunction

    // Memory latency model: ready rises m_lat cycles after enable is seen; -1 never answers.
    always @(posedge clock or negedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_rdy[d] <= 1'b0;
                m_din[d] <= '0;
                m_cnt[d] <= 0;
            end else if (!m_en[d]) begin
                m_rdy[d] <= 1'b0;
                m_cnt[d] <= 0;
            end else if (!m_rdy[d]) begin
                if (m_cnt[d] == m_lat[d]) begin
                    m_rdy[d] <= 1'b1;
                    m_din[d] <= mem_fn(m_addr[d]);
                end
                m_cnt[d] <= m_cnt[d] + 1;
            end
        end
    end

    // Scoreboard: each new memory request is matched against the next expected grant.
    always @(negedge clock) begin : sb_mon
        sb_t e;
        for (int d = 0; d < 2; d++) begin
            if (m_en[d] === 1'b1 && m_en_prev[d] !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_request", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instance", 32'(d), 32'(e.d));
                    check("sb_grant", 32'(gnt[d]), 32'(e.p));
                    check("sb_address", m_addr[d], e.addr);
                    check("sb_data_out", m_dout[d], e.wdata);
                    check("sb_size", 32'(m_size[d]), 32'(e.size));
                    check("sb_operation", 32'(m_op[d]), 32'(e.op));
                end
            end
            m_en_prev[d] <= m_en[d];
        end
    end

    task automatic check_zero(input int d, input string tag);
        check({tag, "_mem_enable"}, 32'(m_en[d]), 32'd0);
        check({tag, "_mem_address"}, m_addr[d], 32'd0);
        check({tag, "_mem_data_out"}, m_dout[d], 32'd0);
        check({tag, "_mem_size"}, 32'(m_size[d]), 32'd0);
        check({tag, "_mem_op"}, 32'(m_op[d]), 32'd0);
        check({tag, "_grant"}, 32'(gnt[d]), 32'd0);
        check({tag, "_timeout_error"}, 32'(terr[d]), 32'd0);
        check({tag, "_ready0"}, 32'(r_rdy[d][0]), 32'd0);
        check({tag, "_ready1"}, 32'(r_rdy[d][1]), 32'd0);
        check({tag, "_data_in0"}, r_din[d][0], 32'd0);
        check({tag, "_data_in1"}, r_din[d][1], 32'd0);
    endtask

    // One requester transaction; call just after a falling edge.
    task automatic txn(input int d, input int p, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic op,
                       input logic [31:0] exp_din, input int hold);
        bit seen;
        logic [31:0] want;
        r_addr[d][p]  = addr;
        r_wdata[d][p] = wdata;
        r_size[d][p]  = size;
        r_op[d][p]    = op;
        r_en[d][p]    = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge clock);
            seen = r_rdy[d][p];
        end
        if (!seen) begin
            check("ready_wait_expired", 32'd0, 32'd1);
            r_en[d][p] = 1'b0;
            return;
        end
        want = op ? model_din[d][p] : exp_din;
        check("data_in", r_din[d][p], want);
        model_din[d][p] = want;
        check("other_data_in", r_din[d][1-p], model_din[d][1-p]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("ready_held", 32'(r_rdy[d][p]), 32'd1);
        end
        r_en[d][p] = 1'b0;
        @(negedge clock);
        check("ready_drop", 32'(r_rdy[d][p]), 32'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_lat[d] = 0;
            for (int p = 0; p < 2; p++) begin
                r_addr[d][p] = '0; r_wdata[d][p] = '0; r_size[d][p] = '0;
                r_en[d][p] = 1'b0; r_op[d][p] = 1'b0; model_din[d][p] = '0;
            end
        end

        //                p  op    size  addr          wdata         lat hold exp_din
        vecs[0] = '{0, 1'b0, 2'd2, 32'h0000_0100, 32'h0000_0000, 1, 2, 32'h1234_5678};
        vecs[1] = '{1, 1'b1, 2'd0, 32'h00FF_FFFD, 32'h0000_0001, 0, 0, 32'h0000_0000};
        vecs[2] = '{0, 1'b1, 2'd1, 32'h2000_0002, 32'hCAFE_BEEF, 3, 1, 32'h0000_0000};
        vecs[3] = '{1, 1'b0, 2'd3, 32'h8000_0004, 32'h0000_0000, 2, 0, 32'hDA5A_5A5E};
        vecs[4] = '{0, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 32'hA5A5_A5A6};

        repeat (3) @(negedge clock);
        check_zero(0, "reset_rr");
        check_zero(1, "reset_fp");
        reset = 1'b1;

        // Round robin from reset: both ports re-request after each of their releases.
        sb_push(0, 0, 32'h1000, 32'h0, 2'd2, 1'b0);
        sb_push(0, 1, 32'h2000, 32'h0, 2'd2, 1'b0);
        sb_push(0, 0, 32'h1004, 32'h0, 2'd2, 1'b0);
        sb_push(0, 1, 32'h2004, 32'h0, 2'd2, 1'b0);
        fork
            begin
                txn(0, 0, 32'h1000, 32'h0, 2'd2, 1'b0, mem_fn(32'h1000), 0);
                txn(0, 0, 32'h1004, 32'h0, 2'd2, 1'b0, mem_fn(32'h1004), 0);
            end
            begin
                txn(0, 1, 32'h2000, 32'h0, 2'd2, 1'b0, mem_fn(32'h2000), 0);
                txn(0, 1, 32'h2004, 32'h0, 2'd2, 1'b0, mem_fn(32'h2004), 0);
            end
        join

        // Fixed priority: port0 keeps winning while it re-requests; port1 waits throughout.
        sb_push(1, 0, 32'h3000, 32'h0, 2'd2, 1'b0);
        sb_push(1, 0, 32'h3004, 32'h0, 2'd2, 1'b0);
        sb_push(1, 0, 32'h3008, 32'h0, 2'd2, 1'b0);
        sb_push(1, 1, 32'h4000, 32'h0, 2'd2, 1'b0);
        fork
            begin
                txn(1, 0, 32'h3000, 32'h0, 2'd2, 1'b0, mem_fn(32'h3000), 0);
                txn(1, 0, 32'h3004, 32'h0, 2'd2, 1'b0, mem_fn(32'h3004), 0);
                txn(1, 0, 32'h3008, 32'h0, 2'd2, 1'b0, mem_fn(32'h3008), 0);
            end
            txn(1, 1, 32'h4000, 32'h0, 2'd2, 1'b0, mem_fn(32'h4000), 0);
        join

        // Single-port vectors on the round-robin instance.
        for (int i = 0; i < 5; i++) begin
            m_lat[0] = vecs[i].lat;
            sb_push(0, vecs[i].p, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].op);
            txn(0, vecs[i].p, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].op,
                vecs[i].exp_din, vecs[i].hold);
        end

        // Watchdog: memory never answers a port0 read.
        m_lat[0] = -1;
        sb_push(0, 0, 32'h300, 32'h0, 2'd2, 1'b0);
        r_addr[0][0] = 32'h300; r_wdata[0][0] = '0; r_size[0][0] = 2'd2; r_op[0][0] = 1'b0;
        r_en[0][0] = 1'b1;
        cyc = 0;
        seen = 1'b0;
        for (int w = 0; w < 60 && !seen; w++) begin
            @(negedge clock);
            if (r_rdy[0][0]) seen = 1'b1;
            else if (m_en[0]) cyc++;
        end
        check("wdog_issue_cycles", 32'(cyc), 32'd8);
        check("wdog_ready", 32'(r_rdy[0][0]), 32'd1);
        check("wdog_mem_enable", 32'(m_en[0]), 32'd0);
        check("wdog_data_in", r_din[0][0], 32'd0);
        check("wdog_error", 32'(terr[0]), 32'd1);
        model_din[0][0] = '0;
        r_en[0][0] = 1'b0;
        @(negedge clock);
        check("wdog_ready_drop", 32'(r_rdy[0][0]), 32'd0);
        check("wdog_error_held", 32'(terr[0]), 32'd1);
        m_lat[0] = 0;
        sb_push(0, 1, 32'h304, 32'h77, 2'd2, 1'b1);
        txn(0, 1, 32'h304, 32'h77, 2'd2, 1'b1, 32'h0, 0);
        check("wdog_error_cleared", 32'(terr[0]), 32'd0);

        // Asynchronous reset while a port1 read is stuck in ISSUE.
        m_lat[0] = -1;
        sb_push(0, 1, 32'h5000, 32'h0, 2'd2, 1'b0);
        r_addr[0][1] = 32'h5000; r_wdata[0][1] = '0; r_size[0][1] = 2'd2; r_op[0][1] = 1'b0;
        r_en[0][1] = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clock);
            seen = m_en[0];
        end
        check("midreset_issue_reached", 32'(seen), 32'd1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero(0, "midreset");
        r_en[0][1] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) model_din[d][p] = '0;
        m_lat[0] = 1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sb_push(0, 1, 32'h5100, 32'h0, 2'd2, 1'b0);
        txn(0, 1, 32'h5100, 32'h0, 2'd2, 1'b0, mem_fn(32'h5100), 0);

        repeat (4) @(negedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
